l_buffer_load_ctrl: RTL and testbench

- Sequencer for the preprocess load of the latency buffer (L_buffer_singleload).
- Takes clause and pointer words from two valid/ready host streams.
- Drives the buffer's load_clause_in / load_change_engine_in / load_ptr_in interface in the required order: per-engine clause groups first, then the flat pointer table.
- Sits between the host preload DMA and the lookup latency buffer; reports busy/done to the top-level init FSM.

---
 rtl/l_buffer_load_ctrl.sv | 120 ++++++++++++
 tb/tb_l_buffer_load_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/l_buffer_load_ctrl.sv
// Preload sequencer for the latency buffer: streams per-engine clause groups,
// then the flat pointer table, from two valid/ready host streams.
module l_buffer_load_ctrl #(
  parameter int NUM_ENGINE  = 2,
  parameter int LIT_IDX_MAX = 4,
  parameter int CLA_LENGTH  = 3,
  parameter int CLQ_DEPTH   = 64,
  localparam int LW        = $clog2(LIT_IDX_MAX) + 1,
  localparam int PW        = $clog2(CLQ_DEPTH),
  localparam int NODE_W    = CLA_LENGTH * (LW + PW),
  localparam int NCW       = $clog2(CLQ_DEPTH) + 1,
  localparam int EW        = (NUM_ENGINE > 1) ? $clog2(NUM_ENGINE) : 1,
  localparam int PTR_TOTAL = NUM_ENGINE * 2 * LIT_IDX_MAX,
  localparam int PCW       = $clog2(PTR_TOTAL + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start_in,
  input  logic [NCW-1:0]    num_cla_in,
  input  logic [NODE_W-1:0] src_cla_in,
  input  logic              src_cla_valid_in,
  output logic              src_cla_ready_out,
  input  logic [PW-1:0]     src_ptr_in,
  input  logic              src_ptr_valid_in,
  output logic              src_ptr_ready_out,
  output logic [NODE_W-1:0] clause_out,
  output logic              load_clause_out,
  output logic              load_change_engine_out,
  output logic [PW-1:0]     ptr_out,
  output logic              load_ptr_out,
  output logic [EW-1:0]     engine_idx_out,
  output logic              busy_out,
  output logic              done_out
);

  typedef enum logic [1:0] {IDLE, CLA, PTR, DONE} state_t;

  state_t            state_q;
  logic [NCW-1:0]    num_cla_q, cla_cnt_q;
  logic [EW-1:0]     eng_cnt_q, eng_o_q;
  logic [PCW-1:0]    ptr_cnt_q;
  logic [NODE_W-1:0] clause_q;
  logic [PW-1:0]     ptr_q;
  logic              load_clause_q, change_q, load_ptr_q, busy_q, done_q;

  assign src_cla_ready_out      = (state_q == CLA);
  assign src_ptr_ready_out      = (state_q == PTR);
  assign clause_out             = clause_q;
  assign load_clause_out        = load_clause_q;
  assign load_change_engine_out = change_q;
  assign ptr_out                = ptr_q;
  assign load_ptr_out           = load_ptr_q;
  assign engine_idx_out         = eng_o_q;
  assign busy_out               = busy_q;
  assign done_out               = done_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q       <= IDLE;
      num_cla_q     <= '0;
      cla_cnt_q     <= '0;
      eng_cnt_q     <= '0;
      eng_o_q       <= '0;
      ptr_cnt_q     <= '0;
      clause_q      <= '0;
      ptr_q         <= '0;
      load_clause_q <= 1'b0;
      change_q      <= 1'b0;
      load_ptr_q    <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      load_clause_q <= 1'b0;
      change_q      <= 1'b0;
      load_ptr_q    <= 1'b0;
      done_q        <= 1'b0;
      case (state_q)
        IDLE: if (start_in) begin
          num_cla_q <= num_cla_in;
          cla_cnt_q <= '0;
          eng_cnt_q <= '0;
          eng_o_q   <= '0;
          ptr_cnt_q <= '0;
          busy_q    <= 1'b1;
          state_q   <= (num_cla_in != '0) ? CLA : PTR;
        end
        CLA: if (src_cla_valid_in) begin
          clause_q      <= src_cla_in;
          load_clause_q <= 1'b1;
          // Change marker rides on the first clause of every engine but engine 0
          change_q      <= (cla_cnt_q == '0) && (eng_cnt_q != '0);
          eng_o_q       <= eng_cnt_q;
          if (cla_cnt_q == num_cla_q - NCW'(1)) begin
            cla_cnt_q <= '0;
            if (eng_cnt_q == EW'(NUM_ENGINE - 1)) state_q <= PTR;
            else eng_cnt_q <= eng_cnt_q + EW'(1);
          end else begin
            cla_cnt_q <= cla_cnt_q + NCW'(1);
          end
        end
        PTR: if (src_ptr_valid_in) begin
          ptr_q      <= src_ptr_in;
          load_ptr_q <= 1'b1;
          eng_o_q    <= EW'(ptr_cnt_q / PCW'(2 * LIT_IDX_MAX));
          ptr_cnt_q  <= ptr_cnt_q + PCW'(1);
          if (ptr_cnt_q == PCW'(PTR_TOTAL - 1)) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_l_buffer_load_ctrl.sv
// Directed bench for l_buffer_load_ctrl: full-rate, gapped, empty-clause and
// mid-sequence-reset load sequences with hand-computed expectations.
module tb_l_buffer_load_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        start_in;
  logic [6:0]  num_cla_in;
  logic [26:0] src_cla_in;
  logic        src_cla_valid_in;
  logic        src_cla_ready_out;
  logic [5:0]  src_ptr_in;
  logic        src_ptr_valid_in;
  logic        src_ptr_ready_out;
  logic [26:0] clause_out;
  logic        load_clause_out;
  logic        load_change_engine_out;
  logic [5:0]  ptr_out;
  logic        load_ptr_out;
  logic [0:0]  engine_idx_out;
  logic        busy_out;
  logic        done_out;

  int checks = 0;
  int errors = 0;

  l_buffer_load_ctrl dut (
    .clock(clock), .reset(reset), .start_in(start_in), .num_cla_in(num_cla_in),
    .src_cla_in(src_cla_in), .src_cla_valid_in(src_cla_valid_in),
    .src_cla_ready_out(src_cla_ready_out), .src_ptr_in(src_ptr_in),
    .src_ptr_valid_in(src_ptr_valid_in), .src_ptr_ready_out(src_ptr_ready_out),
    .clause_out(clause_out), .load_clause_out(load_clause_out),
    .load_change_engine_out(load_change_engine_out), .ptr_out(ptr_out),
    .load_ptr_out(load_ptr_out), .engine_idx_out(engine_idx_out),
    .busy_out(busy_out), .done_out(done_out)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Clause n carries three 9-bit fields 3n, 3n+1, 3n+2
  function automatic logic [26:0] cw(input int n);
    logic [8:0] a, b, c;
    a = 9'(3 * n);
    b = 9'(3 * n + 1);
    c = 9'(3 * n + 2);
    return {c, b, a};
  endfunction

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_lcla"}, 32'(load_clause_out), 0);
    chk({tag, "_chg"},  32'(load_change_engine_out), 0);
    chk({tag, "_lptr"}, 32'(load_ptr_out), 0);
    chk({tag, "_cla"},  32'(clause_out), 0);
    chk({tag, "_ptr"},  32'(ptr_out), 0);
    chk({tag, "_eng"},  32'(engine_idx_out), 0);
    chk({tag, "_busy"}, 32'(busy_out), 0);
    chk({tag, "_done"}, 32'(done_out), 0);
    chk({tag, "_rdyc"}, 32'(src_cla_ready_out), 0);
    chk({tag, "_rdyp"}, 32'(src_ptr_ready_out), 0);
  endtask

  // Start a load, push ncla clauses per engine then 16 pointers.
  // gap=1 drops valid every third cycle on both streams.
  task automatic run_seq(input int ncla, input bit gap);
    int cyc;
    logic [26:0] last_cla;
    logic [5:0]  last_ptr;
    cyc = 0;
    last_cla = clause_out;
    start_in = 1'b1;
    num_cla_in = 7'(ncla);
    step();
    start_in = 1'b0;
    num_cla_in = 7'd5;  // must be ignored once latched
    chk("busy_after_start", 32'(busy_out), 1);
    for (int n = 0; n < 2 * ncla; n++) begin
      if (gap && (cyc % 3 == 2)) begin
        src_cla_valid_in = 1'b0;
        step(); cyc++;
        chk("cla_bubble_pulse", 32'(load_clause_out), 0);
        chk("cla_bubble_hold", 32'(clause_out), 32'(last_cla));
      end
      chk("cla_ready", 32'(src_cla_ready_out), 1);
      chk("cla_ptr_ready_low", 32'(src_ptr_ready_out), 0);
      src_cla_valid_in = 1'b1;
      src_cla_in = cw(n);
      step(); cyc++;
      src_cla_valid_in = 1'b0;
      last_cla = cw(n);
      chk("cla_pulse", 32'(load_clause_out), 1);
      chk("cla_data", 32'(clause_out), 32'(cw(n)));
      chk("cla_change", 32'(load_change_engine_out), 32'((n != 0) && (n % ncla == 0)));
      chk("cla_engine", 32'(engine_idx_out), 32'(n / ncla));
    end
    last_ptr = ptr_out;
    for (int p = 0; p < 16; p++) begin
      if (gap && (cyc % 3 == 2)) begin
        src_ptr_valid_in = 1'b0;
        step(); cyc++;
        chk("ptr_bubble_pulse", 32'(load_ptr_out), 0);
        chk("ptr_bubble_hold", 32'(ptr_out), 32'(last_ptr));
        chk("ptr_bubble_done", 32'(done_out), 0);
      end
      chk("ptr_ready", 32'(src_ptr_ready_out), 1);
      chk("ptr_cla_ready_low", 32'(src_cla_ready_out), 0);
      src_ptr_valid_in = 1'b1;
      src_ptr_in = 6'(p + 1);
      step(); cyc++;
      src_ptr_valid_in = 1'b0;
      last_ptr = 6'(p + 1);
      chk("ptr_pulse", 32'(load_ptr_out), 1);
      chk("ptr_data", 32'(ptr_out), 32'(p + 1));
      chk("ptr_engine", 32'(engine_idx_out), 32'(p / 8));
      chk("ptr_no_change", 32'(load_change_engine_out), 0);
      if (p > 0 || ncla == 0) chk("ptr_no_cla", 32'(load_clause_out), 0);
      chk("ptr_done", 32'(done_out), 32'(p == 15));
      chk("ptr_busy", 32'(busy_out), 1);
    end
    chk("done_ptr_ready_low", 32'(src_ptr_ready_out), 0);
    step();
    chk("post_done", 32'(done_out), 0);
    chk("post_busy", 32'(busy_out), 0);
    chk("post_lptr", 32'(load_ptr_out), 0);
  endtask

  initial begin
    reset = 1'b0;
    start_in = 1'b1;
    num_cla_in = 7'd3;
    src_cla_in = '0;
    src_cla_valid_in = 1'b0;
    src_ptr_in = '0;
    src_ptr_valid_in = 1'b0;
    step();
    step();
    chk_idle_outputs("reset");
    reset = 1'b1;
    start_in = 1'b0;
    step();
    chk("idle_busy", 32'(busy_out), 0);

    run_seq(3, 1'b0);   // full rate
    run_seq(3, 1'b1);   // gapped streams
    run_seq(0, 1'b0);   // no clauses
    run_seq(1, 1'b1);   // single clause per engine

    // Abort after 4 clauses, then replay
    start_in = 1'b1;
    num_cla_in = 7'd3;
    step();
    start_in = 1'b0;
    for (int n = 0; n < 4; n++) begin
      src_cla_valid_in = 1'b1;
      src_cla_in = cw(n);
      step();
    end
    src_cla_valid_in = 1'b0;
    chk("pre_abort_busy", 32'(busy_out), 1);
    reset = 1'b0;
    step();
    chk_idle_outputs("abort");
    reset = 1'b1;
    step();
    chk("abort_no_done", 32'(done_out), 0);
    run_seq(3, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
